cory_monitor_mc: RTL and testbench

Synthesisable multi-channel valid/ready protocol checker and performance monitor. It watches C independent valid/ready/data channels passively and never drives the handshakes. For each channel it flags protocol violations, tracks transfer and stall statistics, and exposes per-channel results through a registered readback port. It is placed beside FIFOs and pipelines for both simulation and on-chip debug.

---
 rtl/cory_monitor_mc.sv | 186 ++++++++++++++++++
 tb/tb_cory_monitor_mc.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cory_monitor_mc.sv
// cory_monitor_mc: passive multi-channel valid/ready protocol checker and
// performance monitor. Each channel runs a small IDLE/WAIT tracker that
// flags valid drops, data changes while stalled and stall timeouts, and
// keeps saturating transfer/valid counters plus current/maximum stall length.
// One channel at a time is exposed on a registered readback port.
module cory_monitor_mc #(
  parameter int C       = 4,
  parameter int N       = 32,
  parameter int W       = 16,
  parameter int MAX_LAT = 100,
  parameter int SW      = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [C-1:0]    i_v,
  input  logic [C*N-1:0]  i_d,
  input  logic [C-1:0]    i_r,
  input  logic            i_clr,
  input  logic [SW-1:0]   i_sel,
  output logic [C-1:0]    o_err,
  output logic            o_err_any,
  output logic [2:0]      o_err_code,
  output logic [W-1:0]    o_cnt_xfer,
  output logic [W-1:0]    o_cnt_valid,
  output logic [W-1:0]    o_lat_max,
  output logic [W-1:0]    o_lat_cur
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  // Error bit positions inside each channel's sticky code.
  localparam int ERR_DROP = 0;
  localparam int ERR_DATA = 1;
  localparam int ERR_TOUT = 2;

  localparam logic [W-1:0] CNT_MAX   = '1;
  localparam logic [W-1:0] MAX_LAT_W = W'(MAX_LAT);

  // Per-channel state.
  state_e         state_q     [C];
  state_e         state_d     [C];
  logic [N-1:0]   cap_q       [C];
  logic [N-1:0]   cap_d       [C];
  logic [W-1:0]   lat_cur_q   [C];
  logic [W-1:0]   lat_cur_d   [C];
  logic [W-1:0]   lat_max_q   [C];
  logic [W-1:0]   lat_max_d   [C];
  logic [W-1:0]   cnt_xfer_q  [C];
  logic [W-1:0]   cnt_xfer_d  [C];
  logic [W-1:0]   cnt_valid_q [C];
  logic [W-1:0]   cnt_valid_d [C];
  logic [2:0]     err_q       [C];
  logic [2:0]     err_d       [C];
  logic [C-1:0]   err_vec_d;

  // Readback mux results (post-update values of the selected channel).
  logic [2:0]     sel_code;
  logic [W-1:0]   sel_xfer;
  logic [W-1:0]   sel_valid;
  logic [W-1:0]   sel_lat_max;
  logic [W-1:0]   sel_lat_cur;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] x);
    return (x == CNT_MAX) ? x : x + W'(1);
  endfunction

  function automatic logic [W-1:0] max_w(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Next-state logic for every channel: clear first, then this cycle's events.
  always_comb begin
    for (int k = 0; k < C; k++) begin
      // NOTE: every comb output gets a default before any branch so no latch
      // is inferred; blocking '=' is correct here, '<=' only in always_ff.
      state_d[k]     = state_q[k];
      cap_d[k]       = cap_q[k];
      lat_cur_d[k]   = lat_cur_q[k];
      lat_max_d[k]   = i_clr ? '0 : lat_max_q[k];
      cnt_xfer_d[k]  = i_clr ? '0 : cnt_xfer_q[k];
      cnt_valid_d[k] = i_clr ? '0 : cnt_valid_q[k];
      err_d[k]       = i_clr ? '0 : err_q[k];

      if (i_v[k]) cnt_valid_d[k] = sat_inc(cnt_valid_d[k]);
      if (i_v[k] && i_r[k]) cnt_xfer_d[k] = sat_inc(cnt_xfer_d[k]);

      case (state_q[k])
        ST_IDLE: begin
          // An immediate accept has latency 0, which never raises lat_max.
          if (i_v[k] && !i_r[k]) begin
            state_d[k]   = ST_WAIT;
            cap_d[k]     = i_d[k*N +: N];
            lat_cur_d[k] = W'(1);
          end
        end
        ST_WAIT: begin
          if (i_v[k]) begin
            if (i_d[k*N +: N] != cap_q[k]) err_d[k][ERR_DATA] = 1'b1;
            if (i_r[k]) begin
              state_d[k]   = ST_IDLE;
              lat_max_d[k] = max_w(lat_max_d[k], lat_cur_q[k]);
              lat_cur_d[k] = '0;
            end else begin
              lat_cur_d[k] = sat_inc(lat_cur_q[k]);
            end
          end else begin
            state_d[k]             = ST_IDLE;
            err_d[k][ERR_DROP]     = 1'b1;
            lat_max_d[k]           = max_w(lat_max_d[k], lat_cur_q[k]);
            lat_cur_d[k]           = '0;
          end
        end
        default: state_d[k] = ST_IDLE;
      endcase

      // Timeout fires only on the step onto MAX_LAT, so once per stall even
      // when the counter saturates at that value.
      if (lat_cur_d[k] == MAX_LAT_W && lat_cur_q[k] != MAX_LAT_W) begin
        err_d[k][ERR_TOUT] = 1'b1;
        lat_max_d[k]       = max_w(lat_max_d[k], MAX_LAT_W);
      end

      err_vec_d[k] = |err_d[k];
    end
  end

  // Readback selection; an out-of-range select matches no channel and reads 0.
  always_comb begin
    sel_code    = '0;
    sel_xfer    = '0;
    sel_valid   = '0;
    sel_lat_max = '0;
    sel_lat_cur = '0;
    for (int k = 0; k < C; k++) begin
      if (i_sel == SW'(k)) begin
        sel_code    = err_d[k];
        sel_xfer    = cnt_xfer_d[k];
        sel_valid   = cnt_valid_d[k];
        sel_lat_max = lat_max_d[k];
        sel_lat_cur = lat_cur_d[k];
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: these per-channel arrays are flop-based state, not RAM, so
      // resetting every entry is intended and keeps captured data defined.
      for (int k = 0; k < C; k++) begin
        state_q[k]     <= ST_IDLE;
        cap_q[k]       <= '0;
        lat_cur_q[k]   <= '0;
        lat_max_q[k]   <= '0;
        cnt_xfer_q[k]  <= '0;
        cnt_valid_q[k] <= '0;
        err_q[k]       <= '0;
      end
      o_err       <= '0;
      o_err_any   <= 1'b0;
      o_err_code  <= '0;
      o_cnt_xfer  <= '0;
      o_cnt_valid <= '0;
      o_lat_max   <= '0;
      o_lat_cur   <= '0;
    end else begin
      for (int k = 0; k < C; k++) begin
        state_q[k]     <= state_d[k];
        cap_q[k]       <= cap_d[k];
        lat_cur_q[k]   <= lat_cur_d[k];
        lat_max_q[k]   <= lat_max_d[k];
        cnt_xfer_q[k]  <= cnt_xfer_d[k];
        cnt_valid_q[k] <= cnt_valid_d[k];
        err_q[k]       <= err_d[k];
      end
      o_err       <= err_vec_d;
      o_err_any   <= |err_vec_d;
      o_err_code  <= sel_code;
      o_cnt_xfer  <= sel_xfer;
      o_cnt_valid <= sel_valid;
      o_lat_max   <= sel_lat_max;
      o_lat_cur   <= sel_lat_cur;
    end
  end

endmodule

// File: tb/tb_cory_monitor_mc.sv
// Bench for cory_monitor_mc: directed stimulus pushes expected readback
// values into a scoreboard queue; a negedge monitor pops and compares.
// Instance A uses default parameters; instance B uses W=4, C=3 to reach
// counter saturation and an out-of-range select.
module tb_cory_monitor_mc;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults.
  logic          a_rst_n, a_clr;
  logic [3:0]    a_v, a_r;
  logic [127:0]  a_d;
  logic [1:0]    a_sel;
  logic [3:0]    a_err;
  logic          a_any;
  logic [2:0]    a_code;
  logic [15:0]   a_xfer, a_valid, a_lmax, a_lcur;

  // Instance B: narrow counters, three channels.
  logic          b_rst_n, b_clr;
  logic [2:0]    b_v, b_r;
  logic [95:0]   b_d;
  logic [1:0]    b_sel;
  logic [2:0]    b_err;
  logic          b_any;
  logic [2:0]    b_code;
  logic [3:0]    b_xfer, b_valid, b_lmax, b_lcur;

  cory_monitor_mc u_a (
    .clk(clk), .reset_n(a_rst_n), .i_v(a_v), .i_d(a_d), .i_r(a_r),
    .i_clr(a_clr), .i_sel(a_sel), .o_err(a_err), .o_err_any(a_any),
    .o_err_code(a_code), .o_cnt_xfer(a_xfer), .o_cnt_valid(a_valid),
    .o_lat_max(a_lmax), .o_lat_cur(a_lcur)
  );

  cory_monitor_mc #(.C(3), .N(32), .W(4), .MAX_LAT(10), .SW(2)) u_b (
    .clk(clk), .reset_n(b_rst_n), .i_v(b_v), .i_d(b_d), .i_r(b_r),
    .i_clr(b_clr), .i_sel(b_sel), .o_err(b_err), .o_err_any(b_any),
    .o_err_code(b_code), .o_cnt_xfer(b_xfer), .o_cnt_valid(b_valid),
    .o_lat_max(b_lmax), .o_lat_cur(b_lcur)
  );

  typedef enum int {F_XFER, F_VALID, F_LMAX, F_LCUR, F_CODE, F_ERR, F_ANY} field_e;
  typedef struct {
    string       name;
    bit          inst_b;
    field_e      fld;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_a(input string name, input field_e f, input logic [31:0] v);
    exp_t e;
    e.name = name; e.inst_b = 1'b0; e.fld = f; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_b(input string name, input field_e f, input logic [31:0] v);
    exp_t e;
    e.name = name; e.inst_b = 1'b1; e.fld = f; e.exp = v;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] actual(input exp_t e);
    logic [31:0] a;
    a = '0;
    if (!e.inst_b) begin
      case (e.fld)
        F_XFER:  a = 32'(a_xfer);
        F_VALID: a = 32'(a_valid);
        F_LMAX:  a = 32'(a_lmax);
        F_LCUR:  a = 32'(a_lcur);
        F_CODE:  a = 32'(a_code);
        F_ERR:   a = 32'(a_err);
        F_ANY:   a = 32'(a_any);
        default: a = '0;
      endcase
    end else begin
      case (e.fld)
        F_XFER:  a = 32'(b_xfer);
        F_VALID: a = 32'(b_valid);
        F_LMAX:  a = 32'(b_lmax);
        F_LCUR:  a = 32'(b_lcur);
        F_CODE:  a = 32'(b_code);
        F_ERR:   a = 32'(b_err);
        F_ANY:   a = 32'(b_any);
        default: a = '0;
      endcase
    end
    return a;
  endfunction

  // Monitor: compare every queued expectation against the stable outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = actual(e);
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n = 1'b0; a_clr = 1'b0; a_v = '0; a_r = '0; a_d = '0; a_sel = 2'd0;
    b_rst_n = 1'b0; b_clr = 1'b0; b_v = '0; b_r = '0; b_d = '0; b_sel = 2'd0;
    step(); step();
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // Reset state.
    expect_a("rst_xfer", F_XFER, 0);
    expect_a("rst_valid", F_VALID, 0);
    expect_a("rst_lmax", F_LMAX, 0);
    expect_a("rst_code", F_CODE, 0);
    expect_a("rst_err", F_ERR, 0);
    expect_a("rst_any", F_ANY, 0);

    // Ten back-to-back transfers on ch0.
    a_d[31:0] = 32'h0000_1234;
    a_v[0] = 1'b1; a_r[0] = 1'b1;
    repeat (10) step();
    a_v[0] = 1'b0; a_r[0] = 1'b0;
    expect_a("b2b_xfer", F_XFER, 10);
    expect_a("b2b_valid", F_VALID, 10);
    expect_a("b2b_lmax", F_LMAX, 0);
    expect_a("b2b_err", F_ERR, 0);

    // ch1: five stall cycles then accept.
    a_sel = 2'd1;
    a_d[63:32] = 32'hA5A5_0001;
    a_v[1] = 1'b1;
    repeat (5) step();
    expect_a("stall_lcur5", F_LCUR, 5);
    a_r[1] = 1'b1;
    step();
    a_v[1] = 1'b0; a_r[1] = 1'b0;
    expect_a("stall_lmax", F_LMAX, 5);
    expect_a("stall_valid", F_VALID, 6);
    expect_a("stall_xfer", F_XFER, 1);
    expect_a("stall_lcur0", F_LCUR, 0);
    expect_a("stall_code", F_CODE, 0);

    // ch2: data change while stalled, then clear alongside continuing stall.
    a_sel = 2'd2;
    a_d[95:64] = 32'hCAFE_0000;
    a_v[2] = 1'b1;
    repeat (2) step();
    a_d[95:64] = 32'h0000_0001;
    step();
    expect_a("dchg_code", F_CODE, 3'b010);
    expect_a("dchg_err", F_ERR, 4'b0100);
    expect_a("dchg_any", F_ANY, 1);
    a_d[95:64] = 32'hCAFE_0000;
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    expect_a("clr_code", F_CODE, 0);
    expect_a("clr_err", F_ERR, 0);
    expect_a("clr_any", F_ANY, 0);
    expect_a("clr_valid_then_event", F_VALID, 1);
    expect_a("clr_lcur_kept", F_LCUR, 4);
    a_r[2] = 1'b1;
    step();
    a_v[2] = 1'b0; a_r[2] = 1'b0;
    expect_a("clr_acc_lmax", F_LMAX, 4);
    expect_a("clr_acc_valid", F_VALID, 2);
    expect_a("clr_acc_xfer", F_XFER, 1);

    // ch3: three stall cycles then valid drop.
    a_sel = 2'd3;
    a_d[127:96] = 32'h0BAD_F00D;
    a_v[3] = 1'b1;
    repeat (3) step();
    a_v[3] = 1'b0;
    step();
    expect_a("drop_code", F_CODE, 3'b001);
    expect_a("drop_lmax", F_LMAX, 3);
    expect_a("drop_xfer", F_XFER, 0);
    expect_a("drop_valid", F_VALID, 3);
    expect_a("drop_err", F_ERR, 4'b1000);

    // Simultaneous drops on ch0 and ch1.
    a_sel = 2'd0;
    a_v[0] = 1'b1; a_v[1] = 1'b1;
    step();
    a_v[0] = 1'b0; a_v[1] = 1'b0;
    step();
    expect_a("sim_err", F_ERR, 4'b1011);
    expect_a("sim_code0", F_CODE, 3'b001);
    expect_a("sim_lmax0", F_LMAX, 1);
    a_sel = 2'd1;
    step();
    expect_a("sim_code1", F_CODE, 3'b001);
    expect_a("sim_lmax1", F_LMAX, 1);

    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    expect_a("clr2_err", F_ERR, 0);
    expect_a("clr2_code", F_CODE, 0);

    // ch0 timeout: 120 stall cycles then accept.
    a_sel = 2'd0;
    a_v[0] = 1'b1; a_r[0] = 1'b0;
    repeat (99) step();
    expect_a("to_lcur99", F_LCUR, 99);
    expect_a("to_code99", F_CODE, 0);
    expect_a("to_lmax99", F_LMAX, 0);
    step();
    expect_a("to_lcur100", F_LCUR, 100);
    expect_a("to_code100", F_CODE, 3'b100);
    expect_a("to_lmax100", F_LMAX, 100);
    expect_a("to_err100", F_ERR, 4'b0001);
    repeat (20) step();
    expect_a("to_lcur120", F_LCUR, 120);
    expect_a("to_lmax120_pre", F_LMAX, 100);
    a_r[0] = 1'b1;
    step();
    a_v[0] = 1'b0; a_r[0] = 1'b0;
    expect_a("to_lmax_acc", F_LMAX, 120);
    expect_a("to_lcur_acc", F_LCUR, 0);
    expect_a("to_xfer_acc", F_XFER, 1);
    expect_a("to_valid_acc", F_VALID, 121);
    expect_a("to_code_acc", F_CODE, 3'b100);

    // Instance B: saturation, out-of-range select, reset mid-stall.
    b_sel = 2'd1;
    b_d[63:32] = 32'h5555_AAAA;
    b_v[1] = 1'b1; b_r[1] = 1'b1;
    repeat (20) step();
    b_v[1] = 1'b0; b_r[1] = 1'b0;
    expect_b("sat_xfer", F_XFER, 15);
    expect_b("sat_valid", F_VALID, 15);
    b_sel = 2'd3;
    step();
    expect_b("oor_xfer", F_XFER, 0);
    expect_b("oor_valid", F_VALID, 0);
    b_sel = 2'd1;
    step();
    expect_b("back_xfer", F_XFER, 15);
    b_v[1] = 1'b1;
    repeat (3) step();
    expect_b("bstall_lcur", F_LCUR, 3);
    expect_b("bstall_code", F_CODE, 0);
    b_rst_n = 1'b0;
    step();
    expect_b("brst_xfer", F_XFER, 0);
    expect_b("brst_valid", F_VALID, 0);
    expect_b("brst_lmax", F_LMAX, 0);
    expect_b("brst_lcur", F_LCUR, 0);
    expect_b("brst_code", F_CODE, 0);
    expect_b("brst_err", F_ERR, 0);
    expect_b("brst_any", F_ANY, 0);
    b_rst_n = 1'b1;
    b_v[1] = 1'b0;
    step();
    expect_b("post_rst_err", F_ERR, 0);
    expect_b("post_rst_code", F_CODE, 0);

    // Let the monitor drain the queue.
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
